// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the data-point RAM row loader.
package ram_loader_pkg;

  localparam int LOADER_LENGTH       = 16;
  localparam int LOADER_MAX_FEATURES = 15;

  // The y word always occupies the topmost slot of a row.
  localparam int Y_SLOT = LOADER_MAX_FEATURES;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SETUP,
    WE,
    HOLD
  } state_t;

  // Bit offset of word slot k within a packed row.
  function automatic int slot_lsb(input int k);
    return k * LOADER_LENGTH;
  endfunction

endpackage

// File: rtl/ram_write_seq.sv
// Three-phase RAM write: address/data settle (SETUP), strobe (WE), hold (HOLD).
// Address and data are captured only when a sequence starts, so they stay
// stable one cycle before, during and one cycle after the write strobe.
module ram_write_seq
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  go_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] row_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  ram_we_o,
  output logic                  ack_o
);

  state_t                  phase_q, phase_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;

  // Phase sequencing: one pass through SETUP, WE, HOLD per go pulse.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      IDLE:    if (go_i) phase_d = SETUP;
      SETUP:   phase_d = WE;
      WE:      phase_d = HOLD;
      HOLD:    phase_d = IDLE;
      default: phase_d = IDLE;
    endcase
  end

  // Phase register plus address/data capture on entry to SETUP.
  always_ff @(posedge clk) begin
    if (RST) begin
      phase_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      if (phase_q == IDLE && go_i) begin
        addr_q <= addr_i;
        data_q <= row_i;
      end
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = data_q;
  assign ram_we_o    = (phase_q == WE);
  assign ack_o       = (phase_q == HOLD);

endmodule

// File: rtl/ram_row_loader.sv
// Packs a word stream (features then y) into RAM rows and writes each row
// through ram_write_seq. Reports busy, a done pulse and a sticky parameter error.
module ram_row_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = LOADER_MAX_FEATURES,
  parameter int LENGTH       = LOADER_LENGTH,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int DEPTH        = 100,
  parameter int FW           = $clog2(MAX_FEATURES + 1)
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  start,
  input  logic [FW-1:0]         num_features,
  input  logic [ADDR_WIDTH-1:0] num_points,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LENGTH-1:0]     in_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rows_written
);

  localparam logic [FW:0]         MAX_NF  = (FW + 1)'(MAX_FEATURES);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  state_t                  state_q, state_d;
  logic [FW-1:0]           nf_q, k_q;
  logic [ADDR_WIDTH-1:0]   np_q, row_q, rows_q;
  logic                    err_q, fin_q, done_q;
  logic [DATA_WIDTH-1:0]   row_buf_q, row_next;
  logic                    hs, params_ok, last_row, go, ack;

  assign params_ok = (num_features != '0) && ({1'b0, num_features} <= MAX_NF) &&
                     (num_points != '0) && (num_points <= DEPTH_A);
  assign hs        = in_valid && (state_q == FILL);
  assign last_row  = (row_q == np_q - ADDR_WIDTH'(1));

  // Row buffer with the word of the current handshake merged in, so the
  // completed row (including y) can be handed to the writer on the same edge.
  always_comb begin
    row_next = row_buf_q;
    if (hs) begin
      if (k_q == nf_q) row_next[slot_lsb(Y_SLOT) +: LENGTH] = in_data;
      else             row_next[slot_lsb(int'(k_q)) +: LENGTH] = in_data;
    end
  end

  // Load FSM next state; go fires on the y handshake.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      IDLE:  if (start && params_ok) state_d = FILL;
      FILL:  if (hs && k_q == nf_q) begin
               state_d = SETUP;
               go      = 1'b1;
             end
      SETUP: state_d = WE;
      WE:    state_d = HOLD;
      HOLD:  if (ack) state_d = last_row ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, latched parameters, counters, error flag, done pulse.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      nf_q    <= '0;
      np_q    <= '0;
      k_q     <= '0;
      row_q   <= '0;
      rows_q  <= '0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= 1'b0;
      done_q  <= fin_q;
      case (state_q)
        IDLE: if (start) begin
                if (params_ok) begin
                  nf_q   <= num_features;
                  np_q   <= num_points;
                  k_q    <= '0;
                  row_q  <= '0;
                  rows_q <= '0;
                  err_q  <= 1'b0;
                end else begin
                  err_q  <= 1'b1;
                end
              end
        FILL: if (hs) k_q <= k_q + FW'(1);
        HOLD: if (ack) begin
                rows_q <= rows_q + ADDR_WIDTH'(1);
                if (last_row) begin
                  fin_q <= 1'b1;
                end else begin
                  row_q <= row_q + ADDR_WIDTH'(1);
                  k_q   <= '0;
                end
              end
        default: ;
      endcase
    end
  end

  // Row buffer: cleared at the start of each row, filled during FILL.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE && start && params_ok) ||
        (state_q == HOLD && ack && !last_row)) begin
      row_buf_q <= '0;
    end else if (state_q == FILL) begin
      row_buf_q <= row_next;
    end
  end

  ram_write_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_write_seq (
    .clk         (clk),
    .RST         (RST),
    .go_i        (go),
    .addr_i      (row_q),
    .row_i       (row_next),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ack_o       (ack)
  );

  assign in_ready     = (state_q == FILL);
  assign busy         = (state_q != IDLE);
  assign ram_oe       = 1'b0;
  assign done         = done_q;
  assign err          = err_q;
  assign rows_written = rows_q;

endmodule

// File: tb/tb_ram_row_loader.sv
// Bench for ram_row_loader: parameter-check table, directed loads, reset
// mid-write, mid-load start, and randomized loads against a row model.
module tb_ram_row_loader;

  localparam int AW = 12;
  localparam int FW = 4;
  localparam int LW = 16;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] num_features = '0;
  logic [AW-1:0] num_points = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_data = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_oe, busy, done, err;
  logic [AW-1:0] rows_written;

  ram_row_loader dut (
    .clk(clk), .RST(RST), .start(start), .num_features(num_features),
    .num_points(num_points), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_oe(ram_oe), .busy(busy), .done(done), .err(err),
    .rows_written(rows_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write pulses and protocol watchers.
  logic [AW-1:0] we_addr_q[$];
  logic [DW-1:0] we_data_q[$];
  int            stab_bad = 0, oe_bad = 0, done_cnt = 0, done_cyc = 0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) begin
    #1;
    if (ram_oe) oe_bad++;
    if (ram_we) begin
      we_addr_q.push_back(ram_addr);
      we_data_q.push_back(ram_wdata);
      if (ram_addr !== prev_addr || ram_wdata !== prev_data) stab_bad++;
    end
    if (prev_we && (ram_addr !== prev_addr || ram_wdata !== prev_data)) stab_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_we   = ram_we;
    prev_addr = ram_addr;
    prev_data = ram_wdata;
  end

  logic [LW-1:0] words [0:255];

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference row: features of point r in slots 0..nf-1, y in the top slot.
  function automatic logic [DW-1:0] model_row(input int nf, input int r);
    logic [DW-1:0] v;
    int base;
    v = '0;
    base = r * (nf + 1);
    for (int j = 0; j < nf; j++) v[j*LW +: LW] = words[base + j];
    v[DW-LW +: LW] = words[base + nf];
    return v;
  endfunction

  // mode: 0 valid held high, 1 toggling, 2 random. mid: pulse start mid-load.
  task automatic run_load(input string tag, input int nf, input int np,
                          input int mode, input bit mid);
    int total, idx, stalls, start_cyc, guard, n;
    bit hs;
    total = np * (nf + 1);
    idx = 0; stalls = 0; guard = 0;
    we_addr_q.delete(); we_data_q.delete();
    stab_bad = 0; oe_bad = 0; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; num_features = FW'(nf); num_points = AW'(np);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    while (!(done_cnt > 0 && idx >= total) && guard < 3000) begin
      if (idx < total) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = (guard % 2 == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = words[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      if (mid && guard == 4) begin
        start = 1'b1; num_features = FW'(nf % 15 + 1); num_points = AW'(np + 1);
      end else begin
        start = 1'b0; num_features = FW'(nf); num_points = AW'(np);
      end
      hs = in_valid && in_ready;
      if (in_ready && !in_valid) stalls++;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk_int({tag, " finished_in_budget"}, int'(guard < 3000), 1);
    chk_int({tag, " done_cycle"}, done_cyc - start_cyc, np * (nf + 4) + 1 + stalls);
    chk_int({tag, " rows_written"}, int'(rows_written), np);
    chk_int({tag, " busy_after"}, int'(busy), 0);
    chk_int({tag, " we_pulses"}, we_addr_q.size(), np);
    n = (we_addr_q.size() < np) ? we_addr_q.size() : np;
    for (int r = 0; r < n; r++) begin
      chk_int({tag, " we_addr"}, int'(we_addr_q[r]), r);
      chk_vec({tag, " row_data"}, we_data_q[r], model_row(nf, r));
    end
    chk_int({tag, " addr_data_stable"}, stab_bad, 0);
    chk_int({tag, " oe_low"}, oe_bad, 0);
    @(negedge clk);
    chk_int({tag, " done_one_pulse"}, done_cnt, 1);
    chk_int({tag, " done_low_after"}, int'(done), 0);
  endtask

  typedef struct {
    int nf;
    int np;
    bit exp_err;
  } pchk_t;

  pchk_t ptab[8];
  int    idx, guard;
  bit    hs;
  logic [DW-1:0] exp_row;

  initial begin
    ptab[0] = '{2, 0, 1'b1};
    ptab[1] = '{2, 3, 1'b0};
    ptab[2] = '{0, 3, 1'b1};
    ptab[3] = '{1, 1, 1'b0};
    ptab[4] = '{2, 101, 1'b1};
    ptab[5] = '{15, 100, 1'b0};
    ptab[6] = '{1, 4095, 1'b1};
    ptab[7] = '{3, 100, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_int("rst in_ready", int'(in_ready), 0);
    chk_int("rst ram_addr", int'(ram_addr), 0);
    chk_vec("rst ram_wdata", ram_wdata, '0);
    chk_int("rst ram_we", int'(ram_we), 0);
    chk_int("rst ram_oe", int'(ram_oe), 0);
    chk_int("rst busy", int'(busy), 0);
    chk_int("rst done", int'(done), 0);
    chk_int("rst err", int'(err), 0);
    chk_int("rst rows_written", int'(rows_written), 0);
    RST = 1'b0;

    // Parameter legality table
    we_addr_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b1; num_features = FW'(ptab[i].nf); num_points = AW'(ptab[i].np);
      @(negedge clk);
      start = 1'b0;
      chk_int("param err", int'(err), int'(ptab[i].exp_err));
      chk_int("param busy", int'(busy), int'(!ptab[i].exp_err));
      if (!ptab[i].exp_err) begin
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
      end
    end
    chk_int("param no_we", we_addr_q.size(), 0);

    // Directed load, valid held high
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h00AA;
    words[3] = 16'h0011; words[4] = 16'h0012; words[5] = 16'h00BB;
    words[6] = 16'h0021; words[7] = 16'h0022; words[8] = 16'h00CC;
    run_load("t1", 2, 3, 0, 1'b0);
    exp_row = {16'h00AA, 208'd0, 16'h0002, 16'h0001};
    if (we_data_q.size() > 0) chk_vec("t1 row0_const", we_data_q[0], exp_row);
    else chk_int("t1 row0_present", 0, 1);

    // Same data with toggling valid
    run_load("t2", 2, 3, 1, 1'b0);

    // Full-width row
    for (int i = 0; i < 15; i++) words[i] = 16'h1000 + 16'(i);
    words[15] = 16'hFFFF;
    run_load("t3", 15, 1, 0, 1'b0);
    exp_row = '0;
    for (int i = 0; i < 15; i++) exp_row[i*16 +: 16] = 16'h1000 + 16'(i);
    exp_row[255:240] = 16'hFFFF;
    if (we_data_q.size() > 0) chk_vec("t3 row0_const", we_data_q[0], exp_row);
    else chk_int("t3 row0_present", 0, 1);

    // Reset during the WE phase of row 1
    for (int i = 0; i < 9; i++) words[i] = 16'($urandom);
    we_addr_q.delete(); we_data_q.delete();
    @(negedge clk);
    start = 1'b1; num_features = 4'd2; num_points = 12'd3;
    @(negedge clk);
    start = 1'b0;
    idx = 0; guard = 0;
    while (!(ram_we && we_addr_q.size() == 2) && guard < 200) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      hs = in_ready;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      guard++;
    end
    chk_int("t5 reached_row1_we", int'(guard < 200), 1);
    chk_int("t5 we_addr_row1", int'(ram_addr), 1);
    RST = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    RST = 1'b0;
    chk_int("t5 we_after_rst", int'(ram_we), 0);
    chk_int("t5 busy_after_rst", int'(busy), 0);
    chk_int("t5 rows_after_rst", int'(rows_written), 0);
    chk_int("t5 addr_after_rst", int'(ram_addr), 0);
    repeat (2) @(negedge clk);
    chk_int("t5 we_stays_low", int'(ram_we), 0);
    chk_int("t5 busy_stays_low", int'(busy), 0);
    for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
    run_load("t5 reload", 2, 2, 0, 1'b0);

    // Start pulsed mid-load
    for (int i = 0; i < 12; i++) words[i] = 16'($urandom);
    run_load("t6", 3, 3, 0, 1'b1);

    // Randomized loads
    for (int t = 0; t < 6; t++) begin
      int nf, np;
      nf = int'($urandom_range(1, 15));
      np = int'($urandom_range(1, 4));
      for (int i = 0; i < np * (nf + 1); i++) words[i] = 16'($urandom);
      run_load("rand", nf, np, 2, t[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_row_loader.md
# ram_row_loader

Upstream loader for the data-point RAM. It accepts a valid/ready stream of LENGTH-bit words (features, then y) and packs each data point into one DATA_WIDTH row. It then writes each row into the RAM through a three-phase address/data/we sequence that is safe for the RAM's level-sensitive write port. It sits between the host/UART word stream and the RAM, and tells the training datapath when the dataset is resident.

## Interface
- ADDR_WIDTH, 12, RAM address width
- MAX_FEATURES, 15, maximum features per point
- LENGTH, 16, bits per feature/y word
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1), RAM row width
- DEPTH, 100, number of RAM rows
- FW, $clog2(MAX_FEATURES+1), width of num_features

Ports:
- clk  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse that begins a load
- num_features  in  FW  features per point; legal range 1..MAX_FEATURES
- num_points  in  ADDR_WIDTH  rows to load; legal range 1..DEPTH
- in_valid  in  1  stream word valid
- in_ready  out  1  loader can accept a word
- in_data  in  LENGTH  stream word
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  row; the top level drives the RAM inout bus with this when ram_we=1
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable; held 0 for the whole load
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the last row is written
- err  out  1  sticky flag for illegal parameters
- rows_written  out  ADDR_WIDTH  count of completed rows

## Operation
- States: IDLE, FILL, SETUP, WE, HOLD.
- **IDLE**
  - start=1 with legal parameters: latch num_features and num_points, clear the row buffer, row=0, rows_written=0, err=0, go to FILL.
  - start=1 with illegal parameters (num_features=0, num_features>MAX_FEATURES, num_points=0, or num_points>DEPTH): set err=1, stay in IDLE, no RAM activity.
- **FILL**
  - in_ready=1. Each handshake (in_valid&&in_ready) stores in_data and increments the word counter k.
  - Words k=0..nf-1 go to slot k, i.e. bits [k*LENGTH +: LENGTH].
  - Word k=nf is y and goes to slot MAX_FEATURES, the top word.
  - Unused slots stay 0.
  - After the y handshake, go to SETUP.
- **SETUP**: ram_addr=row, ram_wdata=buffer, ram_we=0.
- **WE**: ram_we=1; addr and data unchanged.
- **HOLD**: ram_we=0; addr and data unchanged. Then rows_written+1.
  - If row==num_points-1: go to IDLE and pulse done.
  - Otherwise: row+1, clear the buffer, k=0, go to FILL.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- ram_addr and ram_wdata change only on the transition into SETUP. They are therefore stable for the whole period ram_we=1, plus one cycle on each side of it.
- RST in any state:
  - At that edge, go to IDLE and drive all outputs to their reset values.
  - ram_we deasserts at that same edge.
  - RAM contents are not the loader's concern; the shared RST clears the RAM.
- Reset values: in_ready 0, ram_addr 0, ram_wdata 0, ram_we 0, ram_oe 0, busy 0, done 0, err 0, rows_written 0.

## Timing
- Per row: (nf+1) FILL cycles (with in_valid held high) + 3 cycles (SETUP, WE, HOLD) = nf+4 cycles.
- done is high in the cycle that starts np*(nf+4)+1 edges after the edge that sampled start, assuming no stalls. Each stall cycle adds 1.
- ram_we is high for exactly one cycle per row. np rows produce np ram_we pulses at addresses 0..np-1 in order.
- in_ready is 0 in SETUP, WE and HOLD; words presented then are not consumed.
- No combinational path from in_valid to in_ready.

## Structure
- Package ram_loader_pkg holds:
  - the state enum;
  - Y_SLOT = MAX_FEATURES;
  - a helper function slot_lsb(k) = k*LENGTH.
- Sub-module ram_write_seq: owns SETUP/WE/HOLD.
  - Inputs: go, addr, row.
  - Outputs: ram_addr, ram_wdata, ram_we, and ack (asserted in HOLD).
- Top level: FILL control, counters, parameter checking.

## Test plan
1. nf=2, np=3, words 0x0001,0x0002,0x00AA / 0x0011,0x0012,0x00BB / 0x0021,0x0022,0x00CC, in_valid held high.
   -> Three ram_we pulses at addresses 0, 1, 2.
   -> Row 0 = slot0 0x0001, slot1 0x0002, slot15 0x00AA, all other slots 0.
   -> done 19 cycles after start; rows_written=3.
2. Same as test 1 with in_valid toggled 1,0,1,0…
   -> Identical RAM contents and no word loss.
   -> done delayed by exactly the number of stall cycles.
3. nf=15, np=1, words 0x1000..0x100E, then y=0xFFFF.
   -> Every slot filled, slot15=0xFFFF; exactly one ram_we pulse at address 0.
4. start with np=0, then with nf=0, then with np=101.
   -> err=1, busy stays 0, no ram_we.
   -> A following legal start clears err.
5. RST asserted in the WE state of row 1.
   -> ram_we=0, busy=0, rows_written=0 from the next cycle on.
   -> A new start loads cleanly from address 0.
6. start pulsed again mid-load.
   -> Ignored: parameters and counters unchanged, ram_oe=0 throughout.
